// File: rtl/stopwatch_ctrl_if.sv
// Purpose: button inputs and control outputs shared by the stopwatch sequencer.
// Ports: btn_startstop/btn_lap/btn_clear (raw buttons), run_en, clear,
//        freeze, lap_strobe, state[1:0] (registered controls from the sequencer).
interface stopwatch_ctrl_if;
  logic       btn_startstop;
  logic       btn_lap;
  logic       btn_clear;
  logic       run_en;
  logic       clear;
  logic       freeze;
  logic       lap_strobe;
  logic [1:0] state;

  // master drives the buttons and watches the controls (board / bench side)
  modport master (
    output btn_startstop, btn_lap, btn_clear,
    input  run_en, clear, freeze, lap_strobe, state
  );

  // slave is the sequencer itself
  modport slave (
    input  btn_startstop, btn_lap, btn_clear,
    output run_en, clear, freeze, lap_strobe, state
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Purpose: sync + debounce three buttons and run the stopwatch mode FSM.
// Latency: outputs update DEBOUNCE_CYCLES+4 edges after a button is first sampled high.
// Backpressure: none; one event per cycle, priority clear > startstop > lap, rest dropped.
// Ports: clock, reset_n (async active-low), bus (slave side of stopwatch_ctrl_if).
module stopwatch_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input logic             clock,
  input logic             reset_n,
  stopwatch_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    LAP   = 2'b10,
    PAUSE = 2'b11
  } state_t;

  // bit 0 = startstop, bit 1 = lap, bit 2 = clear
  logic [2:0] raw;
  logic [2:0] sync1, sync2;
  logic [2:0] deb, deb_q;
  logic [2:0] ev;

  assign raw = {bus.btn_clear, bus.btn_lap, bus.btn_startstop};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
      deb_q <= '0;
      ev    <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_q <= deb;
      // one pulse per accepted press; releases are silent
      ev    <= deb & ~deb_q;
    end
  end

  for (genvar b = 0; b < 3; b++) begin : g_deb
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        cnt    <= '0;
        deb[b] <= 1'b0;
      end else if (sync2[b] == deb[b]) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        // this cycle is the DEBOUNCE_CYCLES-th consecutive disagreeing sample
        cnt    <= '0;
        deb[b] <= ~deb[b];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  state_t state_q, state_d;
  logic   clear_d, lap_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    clear_d = 1'b0;
    lap_d   = 1'b0;
    // the highest-priority pending event is the only one looked at,
    // even when the current state ignores it
    if (ev[2]) begin
      case (state_q)
        IDLE:    clear_d = 1'b1;
        PAUSE: begin
          clear_d = 1'b1;
          state_d = IDLE;
        end
        default: ;
      endcase
    end else if (ev[0]) begin
      case (state_q)
        IDLE:    state_d = RUN;
        RUN:     state_d = PAUSE;
        LAP:     state_d = PAUSE;
        PAUSE:   state_d = RUN;
        default: state_d = IDLE;
      endcase
    end else if (ev[1]) begin
      case (state_q)
        RUN: begin
          state_d = LAP;
          lap_d   = 1'b1;
        end
        LAP:     state_d = RUN;
        default: ;
      endcase
    end
  end

  // controls are decoded from the next state so they move with state_q
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus.run_en     <= 1'b0;
      bus.freeze     <= 1'b0;
      bus.clear      <= 1'b0;
      bus.lap_strobe <= 1'b0;
    end else begin
      bus.run_en     <= (state_d == RUN) || (state_d == LAP);
      bus.freeze     <= (state_d == LAP);
      bus.clear      <= clear_d;
      bus.lap_strobe <= lap_d;
    end
  end

  assign bus.state = state_q;

endmodule
